// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types and difference-register index map for the warp coordinate generator
package video_pkg;

    localparam int FD_COEFF_W = 32;
    localparam int FD_FRAC_W  = 16;
    localparam int FD_NUM     = 13;

    localparam int FD_P0 = 0;
    localparam int FD_P1 = 1;
    localparam int FD_P2 = 2;
    localparam int FD_P3 = 3;
    localparam int FD_Q0 = 4;
    localparam int FD_Q1 = 5;
    localparam int FD_Q2 = 6;
    localparam int FD_Q3 = 7;
    localparam int FD_R0 = 8;
    localparam int FD_R1 = 9;
    localparam int FD_R2 = 10;
    localparam int FD_S0 = 11;
    localparam int FD_S1 = 12;

    typedef logic signed [FD_COEFF_W-1:0] fd_coeff_t;
    typedef fd_coeff_t [12:0] fd_set_t;

    typedef enum logic {
        FD_IDLE = 1'b0,
        FD_RUN  = 1'b1
    } fd_state_t;

endpackage

// File: rtl/video_fd_axis.sv
// rtl/video_fd_axis.sv - one axis of forward-difference registers; P3 is the current coordinate
module video_fd_axis
    import video_pkg::*;
#(
    parameter int COEFF_W = FD_COEFF_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic                      pix_step,
    input  logic                      line_step,
    input  logic [13*COEFF_W-1:0]     coeff,
    output logic [COEFF_W-1:0]        p3
);

    logic [COEFF_W-1:0] regs_q [FD_NUM];
    logic [COEFF_W-1:0] regs_d [FD_NUM];
    logic [COEFF_W-1:0] q3_n, r2_n, s1_n;

    always_comb begin
        for (int i = 0; i < FD_NUM; i++) begin
            regs_d[i] = regs_q[i];
        end
        q3_n = regs_q[FD_Q3] + regs_q[FD_Q2];
        r2_n = regs_q[FD_R2] + regs_q[FD_R1];
        s1_n = regs_q[FD_S1] + regs_q[FD_S0];
        if (load) begin
            for (int i = 0; i < FD_NUM; i++) begin
                regs_d[i] = coeff[i*COEFF_W +: COEFF_W];
            end
        end else if (pix_step) begin
            regs_d[FD_P3] = regs_q[FD_P3] + regs_q[FD_P2];
            regs_d[FD_P2] = regs_q[FD_P2] + regs_q[FD_P1];
            regs_d[FD_P1] = regs_q[FD_P1] + regs_q[FD_P0];
        end else if (line_step) begin
            // Line start reseeds the pixel-direction differences from the advanced line terms.
            regs_d[FD_Q3] = q3_n;
            regs_d[FD_Q2] = regs_q[FD_Q2] + regs_q[FD_Q1];
            regs_d[FD_Q1] = regs_q[FD_Q1] + regs_q[FD_Q0];
            regs_d[FD_R2] = r2_n;
            regs_d[FD_R1] = regs_q[FD_R1] + regs_q[FD_R0];
            regs_d[FD_S1] = s1_n;
            regs_d[FD_P3] = q3_n;
            regs_d[FD_P2] = r2_n;
            regs_d[FD_P1] = s1_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FD_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FD_NUM; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign p3 = regs_q[FD_P3];

endmodule

// File: rtl/video_fd_coord_gen.sv
// rtl/video_fd_coord_gen.sv - tile walker: FSM, pixel/line counters, clamping and output handshake
module video_fd_coord_gen
    import video_pkg::*;
#(
    parameter int COEFF_W = FD_COEFF_W,
    parameter int FRAC_W  = FD_FRAC_W,
    parameter int TILE_W  = 16,
    parameter int TILE_H  = 16,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [13*COEFF_W-1:0]     coeff_x,
    input  logic [13*COEFF_W-1:0]     coeff_y,
    output logic                      busy,
    output logic                      done,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(IMG_W)-1:0]  out_x_int,
    output logic [7:0]                out_x_frac,
    output logic [$clog2(IMG_H)-1:0]  out_y_int,
    output logic [7:0]                out_y_frac,
    output logic                      out_oob,
    output logic                      out_eol,
    output logic                      out_last
);

    localparam int XW     = $clog2(IMG_W);
    localparam int YW     = $clog2(IMG_H);
    localparam int IW     = COEFF_W - FRAC_W;
    localparam int PIX_W  = $clog2(TILE_W);
    localparam int LINE_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    localparam logic [IW-1:0]     X_MAX   = IW'(IMG_W - 1);
    localparam logic [IW-1:0]     Y_MAX   = IW'(IMG_H - 1);
    localparam logic [XW-1:0]     X_MAX_O = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_MAX_O = YW'(IMG_H - 1);
    localparam logic [PIX_W-1:0]  PIX_END = PIX_W'(TILE_W - 1);
    localparam logic [LINE_W-1:0] LINE_END = LINE_W'(TILE_H - 1);

    fd_state_t           state_q, state_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                done_q, done_d;

    logic                load, pix_step, line_step;
    logic                xfer, eol, last;
    logic [COEFF_W-1:0]  p3_x, p3_y;
    logic [IW-1:0]       x_int_full, y_int_full;
    logic                x_clamp, y_clamp;

    assign out_valid = (state_q == FD_RUN);
    assign busy      = out_valid;
    assign done      = done_q;
    assign xfer      = out_valid & out_ready;
    assign eol       = (pix_q == PIX_END);
    assign last      = eol & (line_q == LINE_END);

    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        line_d    = line_q;
        done_d    = 1'b0;
        load      = 1'b0;
        pix_step  = 1'b0;
        line_step = 1'b0;
        if (abort) begin
            state_d = FD_IDLE;
        end else begin
            case (state_q)
                FD_IDLE: begin
                    if (start) begin
                        load    = 1'b1;
                        state_d = FD_RUN;
                        pix_d   = '0;
                        line_d  = '0;
                    end
                end
                FD_RUN: begin
                    if (xfer) begin
                        if (last) begin
                            state_d = FD_IDLE;
                            done_d  = 1'b1;
                        end else if (eol) begin
                            line_step = 1'b1;
                            pix_d     = '0;
                            line_d    = line_q + 1'b1;
                        end else begin
                            pix_step = 1'b1;
                            pix_d    = pix_q + 1'b1;
                        end
                    end
                end
                default: state_d = FD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FD_IDLE;
            pix_q   <= '0;
            line_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            done_q  <= done_d;
        end
    end

    video_fd_axis #(.COEFF_W(COEFF_W)) u_axis_x (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .pix_step  (pix_step),
        .line_step (line_step),
        .coeff     (coeff_x),
        .p3        (p3_x)
    );

    video_fd_axis #(.COEFF_W(COEFF_W)) u_axis_y (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .pix_step  (pix_step),
        .line_step (line_step),
        .coeff     (coeff_y),
        .p3        (p3_y)
    );

    // Integer part is the arithmetic shift of P3; the sign bit tells a negative coordinate.
    always_comb begin
        x_int_full = p3_x[COEFF_W-1:FRAC_W];
        x_clamp    = 1'b0;
        out_x_int  = x_int_full[XW-1:0];
        if (x_int_full[IW-1]) begin
            x_clamp   = 1'b1;
            out_x_int = '0;
        end else if (x_int_full > X_MAX) begin
            x_clamp   = 1'b1;
            out_x_int = X_MAX_O;
        end
        out_x_frac = x_clamp ? 8'd0 : p3_x[FRAC_W-1 -: 8];
    end

    always_comb begin
        y_int_full = p3_y[COEFF_W-1:FRAC_W];
        y_clamp    = 1'b0;
        out_y_int  = y_int_full[YW-1:0];
        if (y_int_full[IW-1]) begin
            y_clamp   = 1'b1;
            out_y_int = '0;
        end else if (y_int_full > Y_MAX) begin
            y_clamp   = 1'b1;
            out_y_int = Y_MAX_O;
        end
        out_y_frac = y_clamp ? 8'd0 : p3_y[FRAC_W-1 -: 8];
    end

    assign out_oob  = out_valid & (x_clamp | y_clamp);
    assign out_eol  = out_valid & eol;
    assign out_last = out_valid & last;

    logic unused_frac_bits;
    assign unused_frac_bits = &{1'b0, p3_x[FRAC_W-9:0], p3_y[FRAC_W-9:0]};

endmodule

// File: tb/tb_video_fd_coord_gen.sv
// tb/tb_video_fd_coord_gen.sv - directed table-driven bench for the forward-difference coordinate generator
module tb_video_fd_coord_gen;
    import video_pkg::*;

    localparam int IMG_W = 640;
    localparam int IMG_H = 480;

    logic        clk = 1'b0;
    logic        reset_n, start, abort, out_ready;
    fd_set_t     cx, cy;
    logic        busy, done, out_valid, out_oob, out_eol, out_last;
    logic [9:0]  out_x_int;
    logic [8:0]  out_y_int;
    logic [7:0]  out_x_frac, out_y_frac;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_fd_coord_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .coeff_x    (cx),
        .coeff_y    (cy),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x_int  (out_x_int),
        .out_x_frac (out_x_frac),
        .out_y_int  (out_y_int),
        .out_y_frac (out_y_frac),
        .out_oob    (out_oob),
        .out_eol    (out_eol),
        .out_last   (out_last)
    );

    typedef struct {
        fd_set_t    cx;
        fd_set_t    cy;
        int         x0, xp1, xp2, xl1, xl2;
        int         y0, yp1, yp2, yl1, yl2;
        logic [7:0] xf, yf;
        bit         rnd;
    } vec_t;

    vec_t tv [5];

    function automatic fd_set_t mk(int p3, int p2, int p1, int q3, int q2, int q1);
        fd_set_t c;
        c = '0;
        c[FD_P3] = p3;
        c[FD_P2] = p2;
        c[FD_P1] = p1;
        c[FD_Q3] = q3;
        c[FD_Q2] = q2;
        c[FD_Q1] = q1;
        c[FD_R2] = p2;
        c[FD_S1] = p1;
        return c;
    endfunction

    function automatic vec_t mkv(fd_set_t x, fd_set_t y, int x0, int xp1, int xp2, int xl1, int xl2,
                                 int y0, int yp1, int yp2, int yl1, int yl2,
                                 logic [7:0] xf, logic [7:0] yf, bit rnd);
        vec_t v;
        v.cx = x;   v.cy = y;
        v.x0 = x0;  v.xp1 = xp1; v.xp2 = xp2; v.xl1 = xl1; v.xl2 = xl2;
        v.y0 = y0;  v.yp1 = yp1; v.yp2 = yp2; v.yl1 = yl1; v.yl2 = yl2;
        v.xf = xf;  v.yf = yf;   v.rnd = rnd;
        return v;
    endfunction

    // {valid, busy, done, x_int, x_frac, y_int, y_frac, oob, eol, last}
    function automatic logic [40:0] act_vec();
        return {out_valid, busy, done, out_x_int, out_x_frac, out_y_int, out_y_frac,
                out_oob, out_eol, out_last};
    endfunction

    function automatic logic [40:0] exp_vec(int i, int n);
        int p, l, xv, yv;
        logic [9:0] xi;
        logic [8:0] yi;
        logic [7:0] xf, yf;
        logic xo, yo;
        p  = n % 16;
        l  = n / 16;
        xv = tv[i].x0 + tv[i].xp1 * p + tv[i].xp2 * (p * (p - 1) / 2)
           + tv[i].xl1 * l + tv[i].xl2 * (l * (l - 1) / 2);
        yv = tv[i].y0 + tv[i].yp1 * p + tv[i].yp2 * (p * (p - 1) / 2)
           + tv[i].yl1 * l + tv[i].yl2 * (l * (l - 1) / 2);
        xo = (xv < 0) || (xv > IMG_W - 1);
        yo = (yv < 0) || (yv > IMG_H - 1);
        xi = (xv < 0) ? 10'd0 : (xv > IMG_W - 1) ? 10'(IMG_W - 1) : 10'(xv);
        yi = (yv < 0) ? 9'd0  : (yv > IMG_H - 1) ? 9'(IMG_H - 1)  : 9'(yv);
        xf = xo ? 8'd0 : tv[i].xf;
        yf = yo ? 8'd0 : tv[i].yf;
        return {1'b1, 1'b1, 1'b0, xi, xf, yi, yf, xo | yo, p == 15, n == 255};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic run_tile(int i, int abort_at, int start_at, int reset_at, bit chain);
        int n;
        int cyc;
        logic [40:0] e;
        n  = 0;
        cx = tv[i].cx;
        cy = tv[i].cy;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 1; n < 256 && cyc < 3000; cyc++) begin
            e = exp_vec(i, n);
            chk($sformatf("xfer t%0d n%0d", i, n), act_vec(), e);
            if (n == reset_at) begin
                reset_n = 1'b0;
                #1;
                chk("async_reset", act_vec(), '0);
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                return;
            end
            out_ready = tv[i].rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (n == abort_at) begin
                abort     = 1'b1;
                start     = 1'b1;
                out_ready = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                chk("abort_idle_regs_held", act_vec(), {3'b000, e[37:3], 3'b000});
                @(negedge clk);
                chk("abort_no_done", {busy, done, out_valid}, 3'b000);
                return;
            end
            if (n == start_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (out_ready) n++;
        end
        chk("transfer_count", n, 256);
        chk("done_pulse", {out_valid, busy, done}, 3'b001);
        if (!tv[i].rnd) chk("done_cycle", cyc, 257);
        if (!chain) begin
            @(negedge clk);
            chk("done_one_cycle", {out_valid, busy, done}, 3'b000);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        cx        = '0;
        cy        = '0;

        tv[0] = mkv(mk(32'h50000, 0, 0, 32'h50000, 0, 0), '0,
                    5, 0, 0, 0, 0,   0, 0, 0, 0, 0,   8'h00, 8'h00, 1'b0);
        tv[1] = mkv(mk(0, 32'h10000, 0, 0, 0, 0), mk(32'h20000, 0, 0, 32'h20000, 32'h10000, 0),
                    0, 1, 0, 0, 0,   2, 0, 0, 1, 0,   8'h00, 8'h00, 1'b0);
        tv[2] = tv[1];
        tv[2].rnd = 1'b1;
        tv[3] = mkv(mk(-32'sh10000, 0, 0, -32'sh10000, 0, 0),
                    mk((IMG_H + 3) << 16, 0, 0, (IMG_H + 3) << 16, 0, 0),
                    -1, 0, 0, 0, 0,  IMG_H + 3, 0, 0, 0, 0,   8'h00, 8'h00, 1'b0);
        tv[4] = mkv(mk(32'h58000, 32'h10000, 32'h10000, 32'h58000, 0, 0),
                    mk(32'h24000, 0, 0, 32'h24000, 32'h10000, 32'h10000),
                    5, 1, 1, 0, 0,   2, 0, 0, 1, 1,   8'h80, 8'h40, 1'b0);

        repeat (2) @(negedge clk);
        chk("reset_state", act_vec(), '0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", act_vec(), '0);

        run_tile(0, -1, -1, -1, 1'b1);
        run_tile(1, -1, -1, -1, 1'b0);
        run_tile(2, -1, -1, -1, 1'b0);
        run_tile(3, -1, -1, -1, 1'b0);
        run_tile(4, -1, 20, -1, 1'b0);
        run_tile(1, 40, -1, -1, 1'b0);
        run_tile(1, -1, -1, -1, 1'b0);
        run_tile(1, -1, -1, 100, 1'b0);
        run_tile(0, -1, -1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
